// File: rtl/bram_pe_pkg.sv
// Shared encodings for the BRAM fill/verify pattern engine.
package bram_pe_pkg;

    localparam int ERR_W = 16;

    typedef enum logic [1:0] {
        MODE_FILL        = 2'd0,
        MODE_VERIFY      = 2'd1,
        MODE_FILL_VERIFY = 2'd2,
        MODE_SWEEP       = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic is_check_mode(input mode_e m);
        return (m == MODE_VERIFY) || (m == MODE_FILL_VERIFY);
    endfunction

endpackage

// File: rtl/bram_rd_tracker.sv
// Delay line that follows each issued read address through the BRAM read latency.
module bram_rd_tracker #(
    parameter int AW     = 17,
    parameter int RD_LAT = 1
) (
    input  logic          clka,
    input  logic          rsta,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    output logic          tail_valid,
    output logic [AW-1:0] tail_addr
);

    logic [RD_LAT-1:0] vld_r;
    logic [AW-1:0]     addr_r [RD_LAT];

    // Shift valid/address one stage per cycle; reset flushes in-flight reads.
    always_ff @(posedge clka) begin
        if (rsta) begin
            vld_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_r[i] <= '0;
            end
        end else begin
            vld_r[0]  <= push;
            addr_r[0] <= push_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_r[i]  <= vld_r[i-1];
                addr_r[i] <= addr_r[i-1];
            end
        end
    end

    assign tail_valid = vld_r[RD_LAT-1];
    assign tail_addr  = addr_r[RD_LAT-1];

endmodule

// File: rtl/bram_pattern_engine.sv
// Fill/verify sequencer for a single-port BRAM: writes seed+address, reads back,
// counts mismatches and captures the first failing address.
module bram_pattern_engine
    import bram_pe_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 17,
    parameter int DEPTH  = 98304,
    parameter int RD_LAT = 1
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [DW-1:0]    seed,
    output logic             wea,
    output logic [AW-1:0]    addra,
    output logic [DW-1:0]    dina,
    input  logic [DW-1:0]    douta,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [AW-1:0]    first_err_addr
);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [1:0]    DRAIN_LAST = 2'(RD_LAT - 1);

    state_e             state_r;
    mode_e              mode_r;
    logic [DW-1:0]      seed_r;
    logic [1:0]         drain_cnt_r;

    logic               push_s;
    logic               tail_valid_s;
    logic [AW-1:0]      tail_addr_s;
    logic               mismatch_s;
    logic               err_inc_s;
    logic [ERR_W-1:0]   err_cnt_nxt_s;

    function automatic logic [DW-1:0] pattern(input logic [DW-1:0] s, input logic [AW-1:0] a);
        return s + DW'(a);
    endfunction

    assign push_s = (state_r == ST_READ);

    bram_rd_tracker #(
        .AW     (AW),
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clka       (clka),
        .rsta       (rsta),
        .push       (push_s),
        .push_addr  (addra),
        .tail_valid (tail_valid_s),
        .tail_addr  (tail_addr_s)
    );

    // Compare returning data against the expected pattern and form the saturating next count.
    always_comb begin
        mismatch_s = (douta != pattern(seed_r, tail_addr_s));
        err_inc_s  = tail_valid_s && is_check_mode(mode_r) && mismatch_s;
        if (err_inc_s && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt_nxt_s = err_cnt + 16'd1;
        end else begin
            err_cnt_nxt_s = err_cnt;
        end
    end

    // Sequencer FSM with registered BRAM-side and status outputs.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_r        <= ST_IDLE;
            mode_r         <= MODE_FILL;
            seed_r         <= '0;
            drain_cnt_r    <= 2'd0;
            wea            <= 1'b0;
            addra          <= '0;
            dina           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wea   <= 1'b0;
                    addra <= '0;
                    dina  <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        mode_r         <= mode_e'(mode);
                        seed_r         <= seed;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        drain_cnt_r    <= 2'd0;
                        if ((mode == MODE_FILL) || (mode == MODE_FILL_VERIFY)) begin
                            state_r <= ST_WRITE;
                            wea     <= 1'b1;
                            dina    <= seed;
                        end else begin
                            state_r <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (addra == LAST_ADDR) begin
                        wea  <= 1'b0;
                        dina <= '0;
                        if (mode_r == MODE_FILL_VERIFY) begin
                            state_r <= ST_READ;
                            addra   <= '0;
                        end else begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b0;
                        end
                    end else begin
                        addra <= addra + AW'(1);
                        dina  <= pattern(seed_r, addra + AW'(1));
                    end
                end
                ST_READ: begin
                    wea     <= 1'b0;
                    err_cnt <= err_cnt_nxt_s;
                    if (err_inc_s && (err_cnt == '0)) begin
                        first_err_addr <= tail_addr_s;
                    end
                    if (addra == LAST_ADDR) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= 2'd0;
                    end else begin
                        addra <= addra + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    err_cnt <= err_cnt_nxt_s;
                    if (err_inc_s && (err_cnt == '0)) begin
                        first_err_addr <= tail_addr_s;
                    end
                    // The final tail compare lands in the last drain cycle, so pass uses the next count.
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= is_check_mode(mode_r) && (err_cnt_nxt_s == '0);
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    wea     <= 1'b0;
                    addra   <= '0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    wea     <= 1'b0;
                    addra   <= '0;
                    dina    <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_pattern_engine.sv
// Directed bench for bram_pattern_engine: three instances (RD_LAT=1, RD_LAT=2, deep saturation run).
module tb_bram_pattern_engine;

    logic        clka = 1'b0;
    logic        rsta;
    logic        start1, start2, start3;
    logic [1:0]  mode;
    logic [7:0]  seed;

    logic        wea1, busy1, done1, pass1;
    logic [2:0]  addra1, ferr1;
    logic [7:0]  dina1, douta1;
    logic [15:0] err1;

    logic        wea2, busy2, done2, pass2;
    logic [2:0]  addra2, ferr2;
    logic [7:0]  dina2, douta2, rd2_stage;
    logic [15:0] err2;

    logic        wea3, busy3, done3, pass3;
    logic [16:0] addra3, ferr3;
    logic [7:0]  dina3, douta3;
    logic [15:0] err3;

    logic [7:0]  mem1 [8];
    logic [7:0]  mem2 [8];
    logic        cor_en;
    logic [2:0]  cor_addr;
    logic [7:0]  cor_val;

    int n_chk = 0;
    int n_err = 0;
    int busy_n, done_n, max_addr;
    logic [2:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [2:0] ra_q[$];
    logic [7:0] wd2_q[$];
    logic [7:0] exp2 [8];

    always #5 clka = ~clka;

    bram_pattern_engine #(.DW(8), .AW(3), .DEPTH(8), .RD_LAT(1)) u1 (
        .clka(clka), .rsta(rsta), .start(start1), .mode(mode), .seed(seed),
        .wea(wea1), .addra(addra1), .dina(dina1), .douta(douta1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(ferr1)
    );

    bram_pattern_engine #(.DW(8), .AW(3), .DEPTH(8), .RD_LAT(2)) u2 (
        .clka(clka), .rsta(rsta), .start(start2), .mode(mode), .seed(seed),
        .wea(wea2), .addra(addra2), .dina(dina2), .douta(douta2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .first_err_addr(ferr2)
    );

    bram_pattern_engine #(.DW(8), .AW(17), .DEPTH(65537), .RD_LAT(1)) u3 (
        .clka(clka), .rsta(rsta), .start(start3), .mode(mode), .seed(seed),
        .wea(wea3), .addra(addra3), .dina(dina3), .douta(douta3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .first_err_addr(ferr3)
    );

    // BRAM model, latency 1, read-first, with a bench-side corruption port.
    always @(posedge clka) begin
        if (cor_en) mem1[cor_addr] <= cor_val;
        else if (wea1) mem1[addra1] <= dina1;
        douta1 <= mem1[addra1];
    end

    // BRAM model, latency 2.
    always @(posedge clka) begin
        if (wea2) mem2[addra2] <= dina2;
        rd2_stage <= mem2[addra2];
        douta2    <= rd2_stage;
    end

    // Deep model: every word reads back as the complement of its seed-0 pattern.
    always @(posedge clka) douta3 <= ~addra3[7:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic kick1(input logic [1:0] m, input logic [7:0] s);
        @(negedge clka); start1 = 1'b1; mode = m; seed = s;
        @(negedge clka); start1 = 1'b0; mode = ~m; seed = ~s;
    endtask

    // Start u1 and observe until three cycles past done; optional start pokes.
    task automatic run1(input logic [1:0] m, input logic [7:0] s, input int poke_cycle, input bit poke_done);
        int post;
        busy_n = 0; done_n = 0; max_addr = 0; post = -1;
        wa_q.delete(); wd_q.delete(); ra_q.delete();
        kick1(m, s);
        for (int i = 0; i < 300; i++) begin
            if (busy1) busy_n++;
            if (done1) done_n++;
            if (wea1) begin
                wa_q.push_back(addra1);
                wd_q.push_back(dina1);
            end else if (busy1) begin
                ra_q.push_back(addra1);
            end
            if (int'(addra1) > max_addr) max_addr = int'(addra1);
            start1 = (i == poke_cycle) || (poke_done && done1);
            if (done1) post = 0;
            else if (post >= 0) post++;
            if (post == 3) break;
            @(negedge clka);
        end
        start1 = 1'b0;
    endtask

    task automatic corrupt(input logic [2:0] a, input logic [7:0] v);
        @(negedge clka); cor_en = 1'b1; cor_addr = a; cor_val = v;
        @(negedge clka); cor_en = 1'b0;
    endtask

    initial begin
        int bn, dn, w3;
        exp2 = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        rsta = 1'b1; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
        mode = 2'd0; seed = 8'd0; cor_en = 1'b0; cor_addr = 3'd0; cor_val = 8'd0;
        repeat (3) @(negedge clka);
        rsta = 1'b0;
        @(negedge clka);
        chk("reset wea", wea1, 0);
        chk("reset addra", addra1, 0);
        chk("reset dina", dina1, 0);
        chk("reset busy", busy1, 0);
        chk("reset done", done1, 0);
        chk("reset pass", pass1, 0);
        chk("reset err_cnt", err1, 0);
        chk("reset first_err", ferr1, 0);

        // Fill with seed 10.
        run1(2'd0, 8'h10, -1, 1'b0);
        chk("fill busy span", busy_n, 8);
        chk("fill done pulses", done_n, 1);
        chk("fill write count", wa_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("fill addra", wa_q[i], i);
            chk("fill dina", wd_q[i], 8'h10 + i);
        end
        chk("fill no reads", ra_q.size(), 0);
        chk("fill pass", pass1, 0);
        chk("fill max addr", max_addr, 7);

        // Fill+verify on the latency-2 instance with wrapping pattern.
        @(negedge clka); start2 = 1'b1; mode = 2'd2; seed = 8'hFC;
        @(negedge clka); start2 = 1'b0; mode = 2'd1; seed = 8'h00;
        bn = 0; dn = 0; wd2_q.delete();
        for (int i = 0; i < 300; i++) begin
            if (busy2) bn++;
            if (wea2) wd2_q.push_back(dina2);
            if (done2) begin dn++; break; end
            @(negedge clka);
        end
        chk("fv2 done seen", dn, 1);
        chk("fv2 busy span", bn, 18);
        chk("fv2 write count", wd2_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("fv2 dina", wd2_q[i], exp2[i]);
        chk("fv2 pass", pass2, 1);
        chk("fv2 err_cnt", err2, 0);
        chk("fv2 first_err", ferr2, 0);

        // Fill seed 0, corrupt two words, verify.
        run1(2'd0, 8'h00, -1, 1'b0);
        corrupt(3'd3, 8'hAA);
        corrupt(3'd6, 8'h55);
        run1(2'd1, 8'h00, -1, 1'b0);
        chk("verify busy span", busy_n, 9);
        chk("verify done pulses", done_n, 1);
        chk("verify err_cnt", err1, 2);
        chk("verify first_err", ferr1, 3);
        chk("verify pass", pass1, 0);
        chk("verify no writes", wa_q.size(), 0);

        // Starts during WRITE and DONE are ignored.
        run1(2'd0, 8'h20, 3, 1'b1);
        chk("ignore busy span", busy_n, 8);
        chk("ignore done pulses", done_n, 1);
        chk("ignore write count", wa_q.size(), 8);
        chk("ignore idle after", busy1, 0);
        run1(2'd1, 8'h20, -1, 1'b0);
        chk("clean verify pass", pass1, 1);
        chk("clean verify err", err1, 0);

        // Reset in the middle of a read sweep.
        kick1(2'd1, 8'h20);
        for (int i = 0; i < 20; i++) begin
            if (busy1 && !wea1 && addra1 == 3'd4) break;
            @(negedge clka);
        end
        chk("pre-reset addra", addra1, 4);
        rsta = 1'b1;
        @(negedge clka);
        rsta = 1'b0;
        chk("mid reset wea", wea1, 0);
        chk("mid reset addra", addra1, 0);
        chk("mid reset busy", busy1, 0);
        chk("mid reset pass", pass1, 0);
        chk("mid reset err", err1, 0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (done1) dn++;
            @(negedge clka);
        end
        chk("mid reset no done", dn, 0);
        run1(2'd1, 8'h20, -1, 1'b0);
        chk("post reset pass", pass1, 1);
        chk("post reset busy span", busy_n, 9);

        // Read sweep does not check data.
        corrupt(3'd2, 8'h00);
        run1(2'd3, 8'h20, -1, 1'b0);
        chk("sweep busy span", busy_n, 9);
        chk("sweep read count", ra_q.size(), 9);
        for (int i = 0; i < 8; i++) chk("sweep addra", ra_q[i], i);
        chk("sweep err_cnt", err1, 0);
        chk("sweep pass", pass1, 0);

        // Deep verify with every word wrong: count must saturate.
        @(negedge clka); start3 = 1'b1; mode = 2'd1; seed = 8'h00;
        @(negedge clka); start3 = 1'b0; mode = 2'd0; seed = 8'h5A;
        bn = 0; dn = 0; w3 = 0;
        for (int i = 0; i < 70000; i++) begin
            if (busy3) bn++;
            if (wea3) w3++;
            if (done3) begin dn++; break; end
            @(negedge clka);
        end
        chk("sat done seen", dn, 1);
        chk("sat busy span", bn, 65538);
        chk("sat err_cnt", err3, 16'hFFFF);
        chk("sat first_err", ferr3, 0);
        chk("sat pass", pass3, 0);
        chk("sat no writes", w3, 0);
        chk("sat dina idle", dina3, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
